// File: rtl/dab_modulator_if.sv
// dab_modulator_if: parameter inputs and bridge command/gate outputs of the DAB modulator.
// The master drives pulse widths, phase, frequency, dead time and run enable; the slave returns gates.
interface dab_modulator_if;
    logic signed [8:0]  t1;
    logic signed [8:0]  t2;
    logic signed [8:0]  phi;
    logic signed [18:0] fs_dab;
    logic        [7:0]  deadtime;
    logic               sync;
    logic        [3:0]  sp;
    logic        [3:0]  ss;
    logic               trigger;
    logic signed [1:0]  v1;
    logic signed [1:0]  v2;

    modport master (
        output t1, t2, phi, fs_dab, deadtime, sync,
        input  sp, ss, trigger, v1, v2
    );

    modport slave (
        input  t1, t2, phi, fs_dab, deadtime, sync,
        output sp, ss, trigger, v1, v2
    );
endinterface

// File: rtl/dab_modulator.sv
// dab_modulator: three-level DAB bridge modulator with per-leg dead-time FSMs.
// Optional build macro PHI_SAT_EN clamps the latched phase shift to t2 - t1 + 255.
module dab_modulator #(
    parameter int CLK_HZ  = 100000000,
    parameter int PHASE_K = int'(((64'd1 << 32) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ)),
    parameter int FS_MAX  = 250000
) (
    input  logic           clk,
    input  logic           rst,
    dab_modulator_if.slave bus
);

    typedef enum logic [1:0] {ON_HIGH, ON_LOW, DEAD} leg_state_t;
    typedef enum logic [1:0] {TGT_OFF, TGT_HIGH, TGT_LOW} leg_tgt_t;

    function automatic logic [31:0] fs_to_inc(input logic signed [18:0] fs);
        int fs_i;
        fs_i = int'(fs);
        if (fs_i <= 0)
            fs_to_inc = '0;
        else if (fs_i > FS_MAX)
            fs_to_inc = 32'(FS_MAX * PHASE_K);
        else
            fs_to_inc = 32'(fs_i * PHASE_K);
    endfunction

    function automatic logic signed [1:0] level(input logic [8:0] a, input logic signed [8:0] w);
        int ai;
        int wi;
        ai = int'(a);
        wi = int'(w);
        if (ai < wi)
            level = 2'sd1;
        else if (ai < 256)
            level = 2'sd0;
        else if (ai < 256 + wi)
            level = -2'sd1;
        else
            level = 2'sd0;
    endfunction

`ifdef PHI_SAT_EN
    function automatic logic signed [8:0] phi_sat(input logic signed [8:0] phi,
                                                  input logic signed [8:0] w1,
                                                  input logic signed [8:0] w2);
        logic signed [9:0] lim;
        lim = 10'(w2) - 10'(w1) + 10'sd255;
        if (10'(phi) > lim)
            phi_sat = lim[8:0];
        else
            phi_sat = phi;
    endfunction
`endif

    logic signed [18:0] fs_p0;
    logic               sync_p0;
    logic        [7:0]  dt_p0;
    logic        [31:0] phase_p0;
    logic signed [8:0]  t1_l;
    logic signed [8:0]  t2_l;
    logic signed [8:0]  phi_l;
    logic signed [8:0]  phi_next;
    logic        [32:0] sum;
    logic        [8:0]  ang;
    logic        [8:0]  ang2;
    logic        [7:0]  dt_eff;

    // Stage p0: registered inputs, phase accumulator, wrap-time parameter latch
`ifdef PHI_SAT_EN
    assign phi_next = phi_sat(bus.phi, bus.t1, bus.t2);
`else
    assign phi_next = bus.phi;
`endif

    assign sum    = {1'b0, phase_p0} + {1'b0, fs_to_inc(fs_p0)};
    assign dt_eff = (dt_p0 == 8'd0) ? 8'd1 : dt_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_p0    <= '0;
            sync_p0  <= 1'b0;
            dt_p0    <= '0;
            phase_p0 <= '0;
            t1_l     <= 9'sd255;
            t2_l     <= 9'sd147;
            phi_l    <= -9'sd9;
        end else begin
            fs_p0   <= bus.fs_dab;
            sync_p0 <= bus.sync;
            dt_p0   <= bus.deadtime;
            if (!sync_p0) begin
                phase_p0 <= '0;
            end else begin
                phase_p0 <= sum[31:0];
                if (sum[32]) begin
                    t1_l  <= bus.t1;
                    t2_l  <= bus.t2;
                    phi_l <= phi_next;
                end
            end
        end
    end

    // Stage p1: three-level voltage commands and period trigger
    logic signed [1:0] v1_p1;
    logic signed [1:0] v2_p1;
    logic              trigger_p1;
    logic              run_p1;

    assign ang  = phase_p0[31:23];
    // 9-bit modular subtract equals the low bits of the sign-extended 10-bit difference
    assign ang2 = ang - $unsigned(phi_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_p1      <= '0;
            v2_p1      <= '0;
            trigger_p1 <= 1'b0;
            run_p1     <= 1'b0;
        end else begin
            v1_p1      <= sync_p0 ? level(ang, t1_l) : 2'sd0;
            v2_p1      <= sync_p0 ? level(ang2, t2_l) : 2'sd0;
            trigger_p1 <= sync_p0 & ~ang[8];
            run_p1     <= sync_p0;
        end
    end

    // Leg targets: 0 = primary A, 1 = primary B, 2 = secondary A, 3 = secondary B
    leg_tgt_t tgt [4];

    always_comb begin
        tgt[0] = !run_p1 ? TGT_OFF : (v1_p1 == 2'sd1)  ? TGT_HIGH : TGT_LOW;
        tgt[1] = !run_p1 ? TGT_OFF : (v1_p1 == -2'sd1) ? TGT_HIGH : TGT_LOW;
        tgt[2] = !run_p1 ? TGT_OFF : (v2_p1 == 2'sd1)  ? TGT_HIGH : TGT_LOW;
        tgt[3] = !run_p1 ? TGT_OFF : (v2_p1 == -2'sd1) ? TGT_HIGH : TGT_LOW;
    end

    // Stage p2: dead-time FSM per leg; gates are only ever set one-hot from DEAD
    logic [3:0] hi_p2;
    logic [3:0] lo_p2;

    for (genvar g = 0; g < 4; g++) begin : g_leg
        leg_state_t st;
        leg_tgt_t   pend;
        logic [7:0] cnt;
        logic       hi;
        logic       lo;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st   <= DEAD;
                pend <= TGT_OFF;
                cnt  <= '0;
                hi   <= 1'b0;
                lo   <= 1'b0;
            end else if (tgt[g] != pend) begin
                st   <= DEAD;
                pend <= tgt[g];
                cnt  <= dt_eff - 8'd1;
                hi   <= 1'b0;
                lo   <= 1'b0;
            end else if (st == DEAD && pend != TGT_OFF) begin
                if (cnt == 8'd0) begin
                    st <= (pend == TGT_HIGH) ? ON_HIGH : ON_LOW;
                    hi <= (pend == TGT_HIGH);
                    lo <= (pend == TGT_LOW);
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end

        assign hi_p2[g] = hi;
        assign lo_p2[g] = lo;
    end

    assign bus.sp      = {hi_p2[0], lo_p2[0], hi_p2[1], lo_p2[1]};
    assign bus.ss      = {hi_p2[2], lo_p2[2], hi_p2[3], lo_p2[3]};
    assign bus.v1      = v1_p1;
    assign bus.v2      = v2_p1;
    assign bus.trigger = trigger_p1;

endmodule

// File: tb/tb_dab_modulator.sv
// tb_dab_modulator: directed bench for dab_modulator at fs=100 kHz (1 period ~999 clocks).
// Covers reset, default latch values, waveform timing, phase shift, dead time and parameter latching.
module tb_dab_modulator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   shoot_cnt;
    int   v2_diff;

    dab_modulator_if dut_if ();

    dab_modulator dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Continuous check that no leg ever drives both switches
    always @(negedge clk) begin
        if ((dut_if.sp[3] & dut_if.sp[2]) | (dut_if.sp[1] & dut_if.sp[0]) |
            (dut_if.ss[3] & dut_if.ss[2]) | (dut_if.ss[1] & dut_if.ss[0]))
            shoot_cnt <= shoot_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_trig_rise(input string name);
        logic prev;
        bit   ok;
        prev = dut_if.trigger;
        ok   = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!prev && dut_if.trigger) begin
                ok = 1'b1;
                break;
            end
            prev = dut_if.trigger;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: trigger rise not seen within 2500 cycles", name);
        end
    endtask

    task automatic run_len(input logic signed [1:0] val, output int n);
        n = 0;
        while (dut_if.v1 === val && n < 3000) begin
            if (dut_if.v2 !== dut_if.v1) v2_diff++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if (dut_if.sp !== 4'b0000 || dut_if.ss !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_gates: sp=%b ss=%b expected 0000/0000", name, dut_if.sp, dut_if.ss);
        end
        n_checks++;
        if (dut_if.v1 !== 2'sd0 || dut_if.v2 !== 2'sd0) begin
            n_fail++;
            $display("FAIL %s_v: v1=%0d v2=%0d expected 0/0", name, dut_if.v1, dut_if.v2);
        end
        n_checks++;
        if (dut_if.trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_trigger: got %b expected 0", name, dut_if.trigger);
        end
    endtask

    task automatic test_reset;
        rst             = 1'b1;
        dut_if.sync     = 1'b0;
        dut_if.t1       = 9'sd128;
        dut_if.t2       = 9'sd128;
        dut_if.phi      = 9'sd0;
        dut_if.fs_dab   = 19'sd100000;
        dut_if.deadtime = 8'd5;
        step(3);
        check_quiet("reset_hold");
        rst = 1'b0;
        step(20);
        check_quiet("reset_release_idle");
    endtask

    task automatic test_default_latch;
        int n;
        dut_if.sync = 1'b1;
        wait_trig_rise("restart");
        run_len(2'sd1, n);
        n_checks++;
        if (n < 496 || n > 500) begin
            n_fail++;
            $display("FAIL default_t1_width: got %0d cycles expected 496..500", n);
        end
    endtask

    task automatic test_waveform;
        int np, nz1, nn, nz2;
        wait_trig_rise("period_start");
        v2_diff = 0;
        run_len(2'sd1, np);
        run_len(2'sd0, nz1);
        run_len(-2'sd1, nn);
        run_len(2'sd0, nz2);
        n_checks++;
        if (np < 248 || np > 252) begin
            n_fail++;
            $display("FAIL v1_pos_width: got %0d expected 248..252", np);
        end
        n_checks++;
        if (nz1 < 248 || nz1 > 252) begin
            n_fail++;
            $display("FAIL v1_zero1_width: got %0d expected 248..252", nz1);
        end
        n_checks++;
        if (nn < 248 || nn > 252) begin
            n_fail++;
            $display("FAIL v1_neg_width: got %0d expected 248..252", nn);
        end
        n_checks++;
        if (nz2 < 248 || nz2 > 252) begin
            n_fail++;
            $display("FAIL v1_zero2_width: got %0d expected 248..252", nz2);
        end
        n_checks++;
        if (np + nz1 + nn + nz2 < 997 || np + nz1 + nn + nz2 > 1001) begin
            n_fail++;
            $display("FAIL period: got %0d expected 997..1001", np + nz1 + nn + nz2);
        end
        n_checks++;
        if (dut_if.trigger !== 1'b1) begin
            n_fail++;
            $display("FAIL trigger_at_period: got %b expected 1", dut_if.trigger);
        end
        n_checks++;
        if (v2_diff != 0) begin
            n_fail++;
            $display("FAIL v2_equals_v1: got %0d differing cycles expected 0", v2_diff);
        end
    endtask

    // Entered on the sample where v1 has just gone 0 -> +1
    task automatic test_deadtime;
        int k;
        n_checks++;
        if (dut_if.sp !== 4'b0101) begin
            n_fail++;
            $display("FAIL dt_before: sp=%b expected 0101", dut_if.sp);
        end
        step(1);
        n_checks++;
        if (dut_if.sp !== 4'b0001) begin
            n_fail++;
            $display("FAIL dt_sp2_drop: sp=%b expected 0001", dut_if.sp);
        end
        k = 1;
        while (dut_if.sp[3] !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL dt5_delay: got %0d cycles expected 6", k);
        end
        n_checks++;
        if (dut_if.sp !== 4'b1001 || dut_if.ss !== 4'b1001) begin
            n_fail++;
            $display("FAIL dt5_gates: sp=%b ss=%b expected 1001/1001", dut_if.sp, dut_if.ss);
        end
        dut_if.deadtime = 8'd0;
        wait_trig_rise("dt0_edge");
        k = 0;
        while (dut_if.sp[3] !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL dt0_delay: got %0d cycles expected 2", k);
        end
        dut_if.deadtime = 8'd5;
    endtask

    task automatic test_phase_shift;
        int k;
        dut_if.phi = 9'sd64;
        wait_trig_rise("phi_latch");
        k = 0;
        while (dut_if.v2 !== 2'sd1 && k < 600) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k < 123 || k > 127) begin
            n_fail++;
            $display("FAIL phi64_lag: got %0d cycles expected 123..127", k);
        end
    endtask

    task automatic test_param_latch;
        int n;
        wait_trig_rise("latch_period");
        step(50);
        dut_if.t1 = 9'sd64;
        run_len(2'sd1, n);
        n_checks++;
        if (n + 50 < 248 || n + 50 > 252) begin
            n_fail++;
            $display("FAIL t1_midperiod_ignored: got %0d expected 248..252", n + 50);
        end
        wait_trig_rise("latch_next");
        run_len(2'sd1, n);
        n_checks++;
        if (n < 123 || n > 127) begin
            n_fail++;
            $display("FAIL t1_64_pos_width: got %0d expected 123..127", n);
        end
        run_len(2'sd0, n);
        n_checks++;
        if (n < 373 || n > 377) begin
            n_fail++;
            $display("FAIL t1_64_zero_width: got %0d expected 373..377", n);
        end
    endtask

    task automatic test_sync;
        int k;
        dut_if.sync = 1'b0;
        step(10);
        check_quiet("sync_off");
        dut_if.sync = 1'b1;
        k = 0;
        while (dut_if.trigger !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL sync_restart_trigger: got %0d cycles expected 2", k);
        end
        n_checks++;
        if (dut_if.v1 !== 2'sd1) begin
            n_fail++;
            $display("FAIL sync_restart_v1: got %0d expected 1", dut_if.v1);
        end
    endtask

    task automatic test_reset_midrun;
        step(300);
        #3;
        rst = 1'b1;
        #1;
        check_quiet("async_reset");
        dut_if.sync = 1'b0;
        step(3);
        rst = 1'b0;
        step(20);
        check_quiet("post_reset_sync_off");
    endtask

    task automatic test_no_shoot_through;
        step(2);
        n_checks++;
        if (shoot_cnt != 0) begin
            n_fail++;
            $display("FAIL shoot_through: got %0d overlapping samples expected 0", shoot_cnt);
        end
    endtask

`ifdef PHI_SAT_EN
    task automatic test_phi_sat;
        int k;
        dut_if.t1       = 9'sd200;
        dut_if.t2       = 9'sd50;
        dut_if.phi      = 9'sd200;
        dut_if.deadtime = 8'd5;
        dut_if.sync     = 1'b1;
        wait_trig_rise("sat_restart");
        wait_trig_rise("sat_latch");
        k = 0;
        while (dut_if.v2 !== 2'sd1 && k < 800) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k < 203 || k > 207) begin
            n_fail++;
            $display("FAIL phi_sat_lag: got %0d cycles expected 203..207 (phi 105)", k);
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        shoot_cnt = 0;
        v2_diff   = 0;
        test_reset();
        test_default_latch();
        test_waveform();
        test_deadtime();
        test_phase_shift();
        test_param_latch();
        test_sync();
        test_reset_midrun();
`ifdef PHI_SAT_EN
        test_phi_sat();
`endif
        test_no_shoot_through();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
